// File: rtl/dma_addr_gen.sv
// dma_addr_gen: W-bit DMA address / word-count generator with IDLE/RUN/DONE control.
// Optional feature macro: DMA_AUTO_RELOAD_EN -- a terminal step reloads AC/WC from
// AR/init and stays in RUN, pulsing done for one cycle (ring-buffer operation).
module dma_addr_gen #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [2:0]   instr,
  input  logic         instr_vld,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         dout_oe,
  input  logic         step,
  output logic [W-1:0] addr,
  output logic         done,
  output logic         busy,
  output logic         aco,
  output logic         wco
);

  localparam logic [2:0] I_WRCR   = 3'd0;
  localparam logic [2:0] I_RDCR   = 3'd1;
  localparam logic [2:0] I_RDWC   = 3'd2;
  localparam logic [2:0] I_RDAC   = 3'd3;
  localparam logic [2:0] I_REINIT = 3'd4;
  localparam logic [2:0] I_LDADDR = 3'd5;
  localparam logic [2:0] I_LDWC   = 3'd6;
  localparam logic [2:0] I_ENCT   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   ar_q, ar_d;
  logic [W-1:0]   wr_q, wr_d;
  logic [W-1:0]   ac_q, ac_d;
  logic [W-1:0]   wc_q, wc_d;
  logic [3:0]     cr_q, cr_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;
  logic           aco_q, aco_d;
  logic           wco_q, wco_d;

  logic [1:0]     mode;
  logic           dec;
  logic [W-1:0]   ac_nxt;
  logic [W-1:0]   wc_inc;
  logic [W-1:0]   wc_dec;
  logic [W-1:0]   wc_nxt;
  logic [W-1:0]   init_wr;
  logic [W-1:0]   init_din;
  logic           ac_wrap;
  logic           wc_wrap;
  logic           term;

  // Counter arithmetic and reload values derived from the current CR
  assign mode     = cr_q[1:0];
  assign dec      = cr_q[2];
  assign ac_nxt   = dec ? (ac_q - W'(1)) : (ac_q + W'(1));
  assign wc_inc   = wc_q + W'(1);
  assign wc_dec   = wc_q - W'(1);
  assign wc_nxt   = (mode == 2'd1) ? wc_inc : wc_dec;
  assign init_wr  = (mode == 2'd1) ? '0 : wr_q;
  assign init_din = (mode == 2'd1) ? '0 : din;
  assign ac_wrap  = dec ? (ac_q == '0) : (ac_q == '1);
  assign wc_wrap  = (mode == 2'd1) ? (wc_q == '1) : (wc_q == '0);

  // Terminal-count detection on pre-step values
  always_comb begin
    case (mode)
      2'd0:    term = (wc_q == W'(1));
      2'd1:    term = (wc_inc == wr_q);
      2'd2:    term = (ac_nxt == wr_q);
      default: term = 1'b0;
    endcase
  end

  // Zero-latency register reads onto the data bus
  always_comb begin
    dout    = '0;
    dout_oe = 1'b0;
    if (instr_vld) begin
      case (instr)
        I_RDCR: begin dout = W'(cr_q); dout_oe = 1'b1; end
        I_RDWC: begin dout = wc_q;     dout_oe = 1'b1; end
        I_RDAC: begin dout = ac_q;     dout_oe = 1'b1; end
        default: ;
      endcase
    end
  end

  // Next-state and next-register logic; an instruction always wins over a step
  always_comb begin
    state_d = state_q;
    ar_d    = ar_q;
    wr_d    = wr_q;
    ac_d    = ac_q;
    wc_d    = wc_q;
    cr_d    = cr_q;
    done_d  = 1'b0;
    aco_d   = 1'b0;
    wco_d   = 1'b0;
    if (instr_vld) begin
      case (instr)
        I_WRCR:   begin cr_d = din[3:0]; state_d = S_IDLE; end
        I_REINIT: begin ac_d = ar_q; wc_d = init_wr; state_d = S_IDLE; end
        I_LDADDR: begin ar_d = din; ac_d = din; end
        I_LDWC:   begin wr_d = din; wc_d = init_din; end
        I_ENCT:   state_d = S_RUN;
        default:  ;
      endcase
    end else if (step && (state_q == S_RUN)) begin
      if (term) begin
`ifdef DMA_AUTO_RELOAD_EN
        ac_d   = ar_q;
        wc_d   = init_wr;
        done_d = 1'b1;
`else
        ac_d    = ac_nxt;
        wc_d    = wc_nxt;
        aco_d   = ac_wrap;
        wco_d   = wc_wrap;
        state_d = S_DONE;
`endif
      end else begin
        ac_d  = ac_nxt;
        wc_d  = wc_nxt;
        aco_d = ac_wrap;
        wco_d = wc_wrap;
      end
    end
`ifndef DMA_AUTO_RELOAD_EN
    done_d = (state_d == S_DONE);
`endif
    busy_d = (state_d == S_RUN);
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Datapath and registered status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ar_q   <= '0;
      wr_q   <= '0;
      ac_q   <= '0;
      wc_q   <= '0;
      cr_q   <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      aco_q  <= 1'b0;
      wco_q  <= 1'b0;
    end else begin
      ar_q   <= ar_d;
      wr_q   <= wr_d;
      ac_q   <= ac_d;
      wc_q   <= wc_d;
      cr_q   <= cr_d;
      done_q <= done_d;
      busy_q <= busy_d;
      aco_q  <= aco_d;
      wco_q  <= wco_d;
    end
  end

  assign addr = ac_q;
  assign done = done_q;
  assign busy = busy_q;
  assign aco  = aco_q;
  assign wco  = wco_q;

endmodule

// File: doc/dma_addr_gen.md
# dma_addr_gen

Parametrised DMA address/word-count generator, the next generation of the team's 8-bit Am2940-style slice. Generalised to W bits, with a 4-bit command register, an explicit IDLE/RUN/DONE state machine, stop-on-terminal-count behaviour and an instruction-over-step priority rule. It sits between the DMA controller's microsequencer (instructions, data bus) and the memory address bus. It advances one address per accepted transfer (`step`).

## Interface
- `W`, default 16: width of the data bus and of the AR, WR, AC and WC registers (minimum 4).
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `instr` in 3: instruction code.
- `instr_vld` in 1: instruction present this cycle.
- `din` in W: data bus in.
- `dout` in W: data bus out; 0 when not driven.
- `dout_oe` in→out 1: output, high while `dout` carries read data.
- `step` in 1: one transfer completed; advances counters in RUN.
- `addr` out W: current address, equal to AC.
- `done` out 1: terminal count reached.
- `busy` out 1: state is RUN.
- `aco` out 1: one-cycle pulse, AC carry/borrow out on a step.
- `wco` out 1: one-cycle pulse, WC carry/borrow out on a step.

## Operation
- Registers: AR (address reload), WR (word reload/compare), AC (address counter), WC (word counter), CR[3:0].
- CR[1:0] is the mode. CR[2] selects address direction: 0 = increment, 1 = decrement. CR[3] is reserved: it is written and read back but has no function.
- Instructions are executed at the edge where `instr_vld`=1:
  - 0 WRCR: CR←din[3:0]; state→IDLE.
  - 1 RDCR: `dout`={0,CR}.
  - 2 RDWC: `dout`=WC.
  - 3 RDAC: `dout`=AC.
  - 4 REINIT: AC←AR; WC←init; state→IDLE.
  - 5 LDADDR: AR←din; AC←din.
  - 6 LDWC: WR←din; WC←init, computed from din.
  - 7 ENCT: state→RUN.
- init is 0 in mode 1 and WR in all other modes.
- Read instructions (1–3) are combinational. `dout_oe`=`instr_vld` & instr∈{1,2,3}; they change no state.
- Step: in RUN with `step`=1 and no valid instruction that cycle:
  - AC±1 modulo 2^W, direction per CR[2].
  - WC−1 in modes 0, 2 and 3; WC+1 in mode 1, modulo 2^W.
- Terminal condition, evaluated on pre-step values:
  - mode 0: WC==1.
  - mode 1: WC+1==WR.
  - mode 2: next AC==WR.
  - mode 3: never (free-run).
- A step taken with the terminal condition true performs its counter update, then state RUN→DONE.
- FSM:
  - IDLE→RUN on ENCT.
  - RUN→DONE on a terminal step.
  - Any state→IDLE on WRCR or REINIT.
  - DONE→RUN on ENCT.
  - `step` is ignored in IDLE and DONE.
- Priority: a valid instruction and `step` in the same cycle → the instruction executes and the step is dropped (not counted). The controller must re-present it.
- `aco` pulses when AC wraps (all-ones→0 on increment, 0→all-ones on decrement). `wco` pulses the same way for WC.
- Mode-0 edge case: WC=0 at ENCT is not terminal; the count wraps through 2^W steps.

## Timing
- Reset values: AR, WR, AC, WC, CR = 0; state IDLE; `addr`, `dout`, `dout_oe`, `done`, `busy`, `aco`, `wco` = 0.
- Reset is asserted asynchronously and released synchronously to `clk` by the system. Reset mid-RUN aborts the transfer; nothing is retained.
- Load/instruction latency: one edge. A new `addr` is visible the cycle after LDADDR, REINIT or a step.
- Read latency: zero cycles (same cycle as `instr_vld`).
- `done` is registered: high from the cycle after the terminal step until WRCR, REINIT or ENCT.
- `busy`, `aco` and `wco` are registered. `aco`/`wco` are high for exactly the cycle after the wrapping step.

## Configuration
- `DMA_AUTO_RELOAD_EN` defined:
  - A terminal step reloads AC←AR and WC←init instead of entering DONE.
  - State stays RUN.
  - `done` pulses high for exactly one cycle.
  - This gives continuous ring-buffer operation.
- `DMA_AUTO_RELOAD_EN` not defined: stop-on-terminal behaviour as described in Operation.

## Test plan
- Reset mid-RUN: W=16, LDADDR 0x1000, LDWC 3, ENCT, 1 step, then assert `reset_n` low → all outputs 0 immediately; state IDLE.
- Mode 0, increment: LDADDR 0x00F0, LDWC 3, ENCT, 4 steps → `addr` goes F1, F2, F3. `done` rises after the 3rd step; the 4th step is ignored and `addr` stays 0x00F3.
- Mode 2, decrement (CR=4'b0110): LDADDR 0x0005, LDWC 0x0002, ENCT, steps → `addr` goes 4, 3, 2, then DONE.
- Wrap: mode 3, LDADDR 0xFFFF, ENCT, 1 step → `addr`=0x0000 and `aco` is high for exactly one cycle.
- Collision: in RUN, RDAC with `step`=1 in the same cycle → `dout`=current AC, `dout_oe`=1, and AC is unchanged the next cycle.
- With `DMA_AUTO_RELOAD_EN`: mode 0, AR=0x20, WC=2, 5 steps → `addr` goes 21, 20, 21, 20, 21. `done` pulses after steps 2 and 4; `busy` stays 1 throughout.
